// File: rtl/fetch_pkg.sv
// Shared types, constants and the branch-offset helper for the fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam int INSTR_W     = 32;
    localparam int INSTR_BYTES = 4;
    localparam int B_IMM_LSB   = 0;
    localparam int B_IMM_W     = 26;
    localparam int CB_IMM_LSB  = 5;
    localparam int CB_IMM_W    = 19;

    // Byte offset of a taken branch (imm << 2), sign-extended to 32 bits.
    // Callers sign-extend or truncate this to their own address width.
    function automatic logic [31:0] branch_offset(input logic uncond,
                                                  input logic [INSTR_W-1:0] instr);
        logic [31:0] off;
        if (uncond) begin
            off = {{(32 - B_IMM_W - 2){instr[B_IMM_LSB + B_IMM_W - 1]}},
                   instr[B_IMM_LSB +: B_IMM_W], 2'b00};
        end else begin
            off = {{(32 - CB_IMM_W - 2){instr[CB_IMM_LSB + CB_IMM_W - 1]}},
                   instr[CB_IMM_LSB +: CB_IMM_W], 2'b00};
        end
        return off;
    endfunction

endpackage

// File: rtl/fetch_unit_pipelined_if.sv
// Fetch-unit bus bundle: instruction memory, decode handshake and redirect.
// master = fetch unit, slave = memory/decode environment.
interface fetch_unit_pipelined_if #(
    parameter int ADDR_W = 64
);
    import fetch_pkg::*;

    logic                imem_req;
    logic [ADDR_W-1:0]   imem_addr;
    logic [INSTR_W-1:0]  imem_rdata;
    logic                if_valid;
    logic [INSTR_W-1:0]  if_instr;
    logic [ADDR_W-1:0]   if_pc;
    logic                id_ready;
    logic                redirect;
    logic                redirect_uncond;
    logic [ADDR_W-1:0]   redirect_pc;
    logic [INSTR_W-1:0]  redirect_instr;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc,
        input  imem_rdata, id_ready, redirect, redirect_uncond, redirect_pc, redirect_instr
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc,
        output imem_rdata, id_ready, redirect, redirect_uncond, redirect_pc, redirect_instr
    );

endinterface

// File: rtl/fetch_buffer.sv
// Small FIFO of {pc, instr} between instruction memory and decode.
// Flush wins over push; a pop in the flush cycle is simply absorbed by the clear.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DEPTH  = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [ADDR_W-1:0]  push_pc,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic               pop,
    input  logic               flush,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty,
    output logic [ADDR_W-1:0]  head_pc,
    output logic [INSTR_W-1:0] head_instr
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [ADDR_W-1:0]  pc_mem_r    [DEPTH];
    logic [INSTR_W-1:0] instr_mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_nxt_s;
    logic               do_push_s;
    logic               do_pop_s;

    assign empty     = (count_r == '0);
    assign full      = (count_r == DEPTH_C);
    assign count     = count_r;
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Occupancy update from the accepted push/pop pair.
    always_comb begin
        count_nxt_s = count_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer and count registers; flush returns the FIFO to empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            count_r <= count_nxt_s;
        end
    end

    // Entry storage; nothing is written in a flush cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]    <= '0;
                instr_mem_r[i] <= '0;
            end
        end else if (do_push_s && !flush) begin
            pc_mem_r[wr_ptr_r]    <= push_pc;
            instr_mem_r[wr_ptr_r] <= push_instr;
        end
    end

    // Head view, forced to zero while empty so decode never sees stale data.
    always_comb begin
        if (empty) begin
            head_pc    = '0;
            head_instr = '0;
        end else begin
            head_pc    = pc_mem_r[rd_ptr_r];
            head_instr = instr_mem_r[rd_ptr_r];
        end
    end

endmodule

// File: rtl/fetch_unit_pipelined.sv
// Pipelined instruction-fetch front end: owns the PC, issues sequential
// requests to a 1-cycle memory, buffers responses and handles redirects.
module fetch_unit_pipelined
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2
) (
    input  logic                    clk,
    input  logic                    startup_n,
    fetch_unit_pipelined_if.master  bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    fetch_state_t       state_r;
    fetch_state_t       state_nxt_s;
    logic [ADDR_W-1:0]  pc_r;
    logic               epoch_r;
    logic               inflight_r;
    logic [ADDR_W-1:0]  inflight_pc_r;
    logic               inflight_epoch_r;

    logic [CNT_W-1:0]   count_s;
    logic               full_s;
    logic               empty_s;
    logic [ADDR_W-1:0]  head_pc_s;
    logic [INSTR_W-1:0] head_instr_s;

    logic               pop_s;
    logic               push_s;
    logic               space_s;
    logic               req_s;
    logic [OCC_W-1:0]   occ_s;
    logic [OCC_W-1:0]   limit_s;
    logic [31:0]        off32_s;
    logic [ADDR_W-1:0]  off_s;
    logic [ADDR_W-1:0]  target_s;
    logic [ADDR_W-1:0]  pc_plus_s;

    // Target is relative to the branch's own PC, never the fetch PC.
    assign off32_s   = branch_offset(bus.redirect_uncond, bus.redirect_instr);
    assign off_s     = ADDR_W'($signed(off32_s));
    assign target_s  = bus.redirect_pc + off_s;
    assign pc_plus_s = pc_r + ADDR_W'(INSTR_BYTES);

    // A request made now lands next cycle, after this cycle's pop has left,
    // so the pop counts as freed space; that keeps one fetch per cycle.
    assign pop_s   = !empty_s && bus.id_ready;
    assign occ_s   = OCC_W'(count_s) + OCC_W'(inflight_r);
    assign limit_s = OCC_W'(DEPTH) + OCC_W'(pop_s);
    assign space_s = (occ_s < limit_s);

    // Responses from before the last redirect carry the old epoch and are dropped.
    assign push_s = inflight_r && (inflight_epoch_r == epoch_r) && (!full_s || pop_s);

    // Next-state and request decode.
    always_comb begin
        state_nxt_s = state_r;
        req_s       = 1'b0;
        if (state_r == RUN) begin
            req_s = space_s;
        end else begin
            req_s = 1'b0;
        end
        if (bus.redirect) begin
            state_nxt_s = RUN;
        end else begin
            case (state_r)
                BOOT:    state_nxt_s = RUN;
                RUN:     state_nxt_s = space_s ? RUN : HOLD;
                HOLD:    state_nxt_s = space_s ? RUN : HOLD;
                default: state_nxt_s = BOOT;
            endcase
        end
    end

    // PC, FSM state, epoch and in-flight request tracking.
    always_ff @(posedge clk or negedge startup_n) begin
        if (!startup_n) begin
            state_r          <= BOOT;
            pc_r             <= RESET_PC;
            epoch_r          <= 1'b0;
            inflight_r       <= 1'b0;
            inflight_pc_r    <= '0;
            inflight_epoch_r <= 1'b0;
        end else begin
            state_r          <= state_nxt_s;
            inflight_r       <= req_s;
            inflight_pc_r    <= pc_r;
            inflight_epoch_r <= epoch_r;
            if (bus.redirect) begin
                pc_r    <= target_s;
                epoch_r <= ~epoch_r;
            end else if (req_s) begin
                pc_r <= pc_plus_s;
            end
        end
    end

    fetch_buffer #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_buffer (
        .clk        (clk),
        .rst_n      (startup_n),
        .push       (push_s),
        .push_pc    (inflight_pc_r),
        .push_instr (bus.imem_rdata),
        .pop        (pop_s),
        .flush      (bus.redirect),
        .count      (count_s),
        .full       (full_s),
        .empty      (empty_s),
        .head_pc    (head_pc_s),
        .head_instr (head_instr_s)
    );

    assign bus.imem_req  = req_s;
    assign bus.imem_addr = pc_r;
    assign bus.if_valid  = !empty_s;
    assign bus.if_instr  = head_instr_s;
    assign bus.if_pc     = head_pc_s;

endmodule

// File: tb/tb_fetch_unit_pipelined.sv
// Self-checking bench for fetch_unit_pipelined: a 64-bit unit with
// RESET_PC=0 and a 16-bit unit with RESET_PC=0x100, both fed by
// address-encoding one-cycle memories.
module tb_fetch_unit_pipelined;

    logic clk = 1'b0;
    logic startup_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    logic [63:0] exp_q[$];

    fetch_unit_pipelined_if #(.ADDR_W(64)) bus_a ();
    fetch_unit_pipelined_if #(.ADDR_W(16)) bus_b ();

    fetch_unit_pipelined #(.ADDR_W(64), .RESET_PC(64'd0), .DEPTH(2)) dut_a (
        .clk(clk), .startup_n(startup_n), .bus(bus_a));
    fetch_unit_pipelined #(.ADDR_W(16), .RESET_PC(16'h0100), .DEPTH(2)) dut_b (
        .clk(clk), .startup_n(startup_n), .bus(bus_b));

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [63:0] a);
        return a[31:0] ^ 32'h3C00_0000;
    endfunction

    // One-cycle instruction memories returning address-encoded words
    always @(posedge clk) begin
        bus_a.imem_rdata <= bus_a.imem_req ? enc(bus_a.imem_addr) : 32'hDEAD_BEEF;
        bus_b.imem_rdata <= bus_b.imem_req ? enc({48'd0, bus_b.imem_addr}) : 32'hDEAD_BEEF;
    end

    task automatic test_reset();
        startup_n = 1'b0;
        bus_a.id_ready = 1'b0; bus_a.redirect = 1'b0; bus_a.redirect_uncond = 1'b0;
        bus_a.redirect_pc = 64'd0; bus_a.redirect_instr = 32'd0;
        bus_b.id_ready = 1'b0; bus_b.redirect = 1'b0; bus_b.redirect_uncond = 1'b0;
        bus_b.redirect_pc = 16'd0; bus_b.redirect_instr = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        n_total++; if (bus_a.imem_req !== 1'b0) $display("FAIL rst_req got %b exp 0", bus_a.imem_req); else n_pass++;
        n_total++; if (bus_a.imem_addr !== 64'd0) $display("FAIL rst_addr got %h exp 0", bus_a.imem_addr); else n_pass++;
        n_total++; if (bus_a.if_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", bus_a.if_valid); else n_pass++;
        n_total++; if (bus_a.if_instr !== 32'd0) $display("FAIL rst_instr got %h exp 0", bus_a.if_instr); else n_pass++;
        n_total++; if (bus_a.if_pc !== 64'd0) $display("FAIL rst_pc got %h exp 0", bus_a.if_pc); else n_pass++;
        n_total++; if (bus_b.imem_addr !== 16'h0100) $display("FAIL rst_addr_b got %h exp 0100", bus_b.imem_addr); else n_pass++;
    endtask

    task automatic test_stream();
        logic [63:0] e;
        exp_q = {};
        for (int i = 0; i < 4; i++) exp_q.push_back(64'(4 * i));
        bus_a.id_ready = 1'b1;
        bus_b.id_ready = 1'b1;
        @(negedge clk); startup_n = 1'b1; #1;                       // cycle 0
        n_total++; if (bus_a.imem_req !== 1'b0) $display("FAIL c0_req got %b exp 0", bus_a.imem_req); else n_pass++;
        @(negedge clk); #1;                                          // cycle 1
        n_total++; if (bus_a.imem_req !== 1'b1 || bus_a.imem_addr !== 64'd0)
            $display("FAIL c1_req got %b/%h exp 1/0", bus_a.imem_req, bus_a.imem_addr); else n_pass++;
        @(negedge clk); #1;                                          // cycle 2
        n_total++; if (bus_a.if_valid !== 1'b0) $display("FAIL c2_valid got %b exp 0", bus_a.if_valid); else n_pass++;
        for (int c = 3; c <= 5; c++) begin
            @(negedge clk); #1;
            n_total++; if (bus_a.if_valid !== 1'b1) $display("FAIL stream_valid c%0d got %b exp 1", c, bus_a.if_valid); else n_pass++;
            if (bus_a.if_valid === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_total++; if (bus_a.if_pc !== e || bus_a.if_instr !== enc(e))
                    $display("FAIL stream_pc got %h/%h exp %h/%h", bus_a.if_pc, bus_a.if_instr, e, enc(e)); else n_pass++;
            end
        end
    endtask

    task automatic test_redirect_uncond();
        @(negedge clk);                                              // R: head pc 12
        bus_a.redirect = 1'b1; bus_a.redirect_uncond = 1'b1;
        bus_a.redirect_instr = 32'h1400_0007; bus_a.redirect_pc = 64'd12;
        #1;
        n_total++; if (bus_a.if_valid !== 1'b1 || bus_a.if_pc !== 64'd12)
            $display("FAIL br_head got %b/%h exp 1/c", bus_a.if_valid, bus_a.if_pc); else n_pass++;
        @(negedge clk); bus_a.redirect = 1'b0; #1;                   // R+1
        n_total++; if (bus_a.imem_req !== 1'b1 || bus_a.imem_addr !== 64'd40)
            $display("FAIL br_addr got %b/%h exp 1/28", bus_a.imem_req, bus_a.imem_addr); else n_pass++;
        n_total++; if (bus_a.if_valid !== 1'b0) $display("FAIL br_r1_valid got %b exp 0", bus_a.if_valid); else n_pass++;
        @(negedge clk); #1;                                          // R+2
        n_total++; if (bus_a.if_valid !== 1'b0) $display("FAIL br_r2_valid got %b exp 0", bus_a.if_valid); else n_pass++;
    endtask

    task automatic test_redirect_cb();
        logic [63:0] e;
        @(negedge clk);                                              // R+3 of previous redirect
        bus_a.redirect = 1'b1; bus_a.redirect_uncond = 1'b0;
        bus_a.redirect_instr = 32'hB4FF_FFE0; bus_a.redirect_pc = 64'd40;
        #1;
        n_total++; if (bus_a.if_valid !== 1'b1 || bus_a.if_pc !== 64'd40 || bus_a.if_instr !== enc(64'd40))
            $display("FAIL uncond_target got %b/%h exp 1/28", bus_a.if_valid, bus_a.if_pc); else n_pass++;
        @(negedge clk); bus_a.redirect = 1'b0; #1;
        n_total++; if (bus_a.imem_req !== 1'b1 || bus_a.imem_addr !== 64'd36 || bus_a.if_valid !== 1'b0)
            $display("FAIL cb_addr got %b/%h/%b exp 1/24/0", bus_a.imem_req, bus_a.imem_addr, bus_a.if_valid); else n_pass++;
        @(negedge clk); #1;
        n_total++; if (bus_a.if_valid !== 1'b0) $display("FAIL cb_r2_valid got %b exp 0", bus_a.if_valid); else n_pass++;
        exp_q = {};
        for (int i = 0; i < 32; i++) exp_q.push_back(64'd36 + 64'(4 * i));
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            n_total++; if (bus_a.if_valid !== 1'b1) $display("FAIL cb_valid c%0d got %b exp 1", c, bus_a.if_valid); else n_pass++;
            if (bus_a.if_valid === 1'b1) begin
                e = exp_q.pop_front();
                n_total++; if (bus_a.if_pc !== e || bus_a.if_instr !== enc(e))
                    $display("FAIL cb_pc got %h/%h exp %h/%h", bus_a.if_pc, bus_a.if_instr, e, enc(e)); else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] e;
        int xfers = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); bus_a.id_ready = 1'b0; #1;
            n_total++; if (bus_a.if_valid !== 1'b1 || bus_a.if_pc !== exp_q[0])
                $display("FAIL stall_head c%0d got %b/%h exp 1/%h", c, bus_a.if_valid, bus_a.if_pc, exp_q[0]); else n_pass++;
            n_total++; if (bus_a.imem_req !== 1'b0) $display("FAIL stall_req c%0d got %b exp 0", c, bus_a.imem_req); else n_pass++;
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); bus_a.id_ready = 1'b1; #1;
            if (bus_a.if_valid === 1'b1) begin
                xfers++;
                e = exp_q.pop_front();
                n_total++; if (bus_a.if_pc !== e || bus_a.if_instr !== enc(e))
                    $display("FAIL resume_pc got %h/%h exp %h/%h", bus_a.if_pc, bus_a.if_instr, e, enc(e)); else n_pass++;
            end
        end
        n_total++; if (xfers < 8) $display("FAIL resume_rate got %0d exp >=8", xfers); else n_pass++;
    endtask

    task automatic test_wrap16();
        logic [15:0] pcs [3];
        pcs[0] = 16'hFFFC; pcs[1] = 16'h0000; pcs[2] = 16'h0004;
        @(negedge clk);
        bus_b.redirect = 1'b1; bus_b.redirect_uncond = 1'b1;
        bus_b.redirect_instr = 32'h1400_0001; bus_b.redirect_pc = 16'hFFF8;
        @(negedge clk); bus_b.redirect = 1'b0; #1;
        n_total++; if (bus_b.imem_req !== 1'b1 || bus_b.imem_addr !== 16'hFFFC)
            $display("FAIL wrap_target got %b/%h exp 1/fffc", bus_b.imem_req, bus_b.imem_addr); else n_pass++;
        @(negedge clk); #1;
        n_total++; if (bus_b.imem_req !== 1'b1 || bus_b.imem_addr !== 16'h0000)
            $display("FAIL wrap_addr got %b/%h exp 1/0000", bus_b.imem_req, bus_b.imem_addr); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_total++; if (bus_b.if_valid !== 1'b1 || bus_b.if_pc !== pcs[i] || bus_b.if_instr !== enc({48'd0, pcs[i]}))
                $display("FAIL wrap_pc got %b/%h exp 1/%h", bus_b.if_valid, bus_b.if_pc, pcs[i]); else n_pass++;
        end
    endtask

    task automatic test_midstream_reset();
        @(negedge clk); #1;
        n_total++; if (bus_a.if_valid !== 1'b1) $display("FAIL pre_rst_valid got %b exp 1", bus_a.if_valid); else n_pass++;
        #2 startup_n = 1'b0;
        #1;
        n_total++; if (bus_a.if_valid !== 1'b0 || bus_a.if_instr !== 32'd0 || bus_a.if_pc !== 64'd0)
            $display("FAIL async_rst got %b/%h/%h exp 0/0/0", bus_a.if_valid, bus_a.if_instr, bus_a.if_pc); else n_pass++;
        n_total++; if (bus_b.if_valid !== 1'b0 || bus_b.imem_addr !== 16'h0100 || bus_b.imem_req !== 1'b0)
            $display("FAIL async_rst_b got %b/%h/%b exp 0/0100/0", bus_b.if_valid, bus_b.imem_addr, bus_b.imem_req); else n_pass++;
        @(negedge clk);
        @(negedge clk); startup_n = 1'b1; #1;                        // cycle 0
        n_total++; if (bus_b.imem_req !== 1'b0) $display("FAIL rel_c0_req got %b exp 0", bus_b.imem_req); else n_pass++;
        @(negedge clk); #1;                                          // cycle 1
        n_total++; if (bus_b.imem_req !== 1'b1 || bus_b.imem_addr !== 16'h0100)
            $display("FAIL rel_c1_addr got %b/%h exp 1/0100", bus_b.imem_req, bus_b.imem_addr); else n_pass++;
        @(negedge clk); #1;                                          // cycle 2
        n_total++; if (bus_a.if_valid !== 1'b0 || bus_b.if_valid !== 1'b0)
            $display("FAIL rel_c2_valid got %b/%b exp 0/0", bus_a.if_valid, bus_b.if_valid); else n_pass++;
        @(negedge clk); #1;                                          // cycle 3
        n_total++; if (bus_b.if_valid !== 1'b1 || bus_b.if_pc !== 16'h0100 || bus_b.if_instr !== enc(64'h100))
            $display("FAIL rel_first_b got %b/%h exp 1/0100", bus_b.if_valid, bus_b.if_pc); else n_pass++;
        n_total++; if (bus_a.if_valid !== 1'b1 || bus_a.if_pc !== 64'd0 || bus_a.if_instr !== enc(64'd0))
            $display("FAIL rel_first_a got %b/%h exp 1/0", bus_a.if_valid, bus_a.if_pc); else n_pass++;
    endtask

    // Test sequence
    initial begin
        test_reset();
        test_stream();
        test_redirect_uncond();
        test_redirect_cb();
        test_backpressure();
        test_wrap16();
        test_midstream_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
